// File: rtl/x_mem_responder.sv
// Coprocessor memory-interface responder: turns x_mem requests into single-beat data-bus
// transactions and returns in-order results. Define FPU_SS_MEM_MISALIGN_EXC_EN to fault misaligned accesses.
package x_mem_responder_pkg;
  localparam int X_ID_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic [31:0]       addr;
    logic [1:0]        mode;
    mem_size_e         size;
    logic              we;
    logic [31:0]       wdata;
    logic              last;
    logic              spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic [31:0]       rdata;
    logic              err;
    logic              dbg;
  } x_mem_result_t;
endpackage

module x_mem_responder
  import x_mem_responder_pkg::*;
#(
  parameter int X_ID_WIDTH = X_ID_W,
  parameter int DEPTH      = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          x_mem_valid_i,
  output logic          x_mem_ready_o,
  input  x_mem_req_t    x_mem_req_i,
  output x_mem_resp_t   x_mem_resp_o,
  output logic          x_mem_result_valid_o,
  output x_mem_result_t x_mem_result_o,
  output logic          data_req_o,
  input  logic          data_gnt_i,
  output logic [31:0]   data_addr_o,
  output logic          data_we_o,
  output logic [3:0]    data_be_o,
  output logic [31:0]   data_wdata_o,
  input  logic          data_rvalid_i,
  input  logic [31:0]   data_rdata_i,
  input  logic          data_err_i
);

  typedef enum logic {IDLE, BUS_REQ} state_e;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [1:0]            off;
    mem_size_e             size;
    logic                  we;
  } entry_t;

  state_e      state_q;
  logic        out_of_reset_q;
  entry_t      pend_q;
  entry_t      fifo_q [DEPTH];
  ptr_t        wptr_q, rptr_q;
  cnt_t        count_q;

  logic [1:0]  req_off;
  logic        is_double, misaligned, fault, full, bus_accept, push, pop;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  entry_t      head;
  logic [31:0] rd_shift, load_rdata;

  // mode, last and spec have no effect on the transaction.
  logic unused_req_fields;
  assign unused_req_fields = ^{x_mem_req_i.mode, x_mem_req_i.last, x_mem_req_i.spec};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    req_off      = x_mem_req_i.addr[1:0];
    is_double    = (x_mem_req_i.size == SIZE_DOUBLE);
`ifdef FPU_SS_MEM_MISALIGN_EXC_EN
    misaligned   = ((x_mem_req_i.size == SIZE_HALF) && req_off[0]) ||
                   ((x_mem_req_i.size == SIZE_WORD) && (req_off != 2'b00));
`else
    misaligned   = 1'b0;
`endif
    fault        = is_double | misaligned;
    full         = (count_q == cnt_t'(DEPTH));

    case (x_mem_req_i.size)
      SIZE_BYTE: req_be = 4'b0001 << req_off;
      SIZE_HALF: req_be = 4'b0011 << req_off;
      default:   req_be = 4'b1111;
    endcase
    req_wdata    = x_mem_req_i.wdata << {req_off, 3'b000};

    // out_of_reset_q keeps ready low while rst_ni is asserted even if valid is high.
    x_mem_ready_o = out_of_reset_q && (state_q == IDLE) && x_mem_valid_i && !full;
    bus_accept    = x_mem_ready_o && !fault;

    x_mem_resp_o = '0;
    if (x_mem_ready_o && fault) begin
      x_mem_resp_o.exc     = 1'b1;
      x_mem_resp_o.exccode = x_mem_req_i.we ? (is_double ? 6'd7 : 6'd6)
                                            : (is_double ? 6'd5 : 6'd4);
    end

    push = (state_q == BUS_REQ) && data_gnt_i;
    pop  = data_rvalid_i && (count_q != '0);
  end

  always_comb begin
    head     = fifo_q[rptr_q];
    rd_shift = data_rdata_i >> {head.off, 3'b000};
    case (head.size)
      SIZE_BYTE: load_rdata = {24'b0, rd_shift[7:0]};
      SIZE_HALF: load_rdata = {16'b0, rd_shift[15:0]};
      default:   load_rdata = rd_shift;
    endcase
    if (head.we) load_rdata = '0;
  end

  // Request FSM; bus outputs are registered and held until the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q        <= IDLE;
      out_of_reset_q <= 1'b0;
      pend_q         <= '0;
      data_req_o     <= 1'b0;
      data_addr_o    <= '0;
      data_we_o      <= 1'b0;
      data_be_o      <= '0;
      data_wdata_o   <= '0;
    end else begin
      out_of_reset_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (bus_accept) begin
            state_q      <= BUS_REQ;
            data_req_o   <= 1'b1;
            data_addr_o  <= {x_mem_req_i.addr[31:2], 2'b00};
            data_we_o    <= x_mem_req_i.we;
            data_be_o    <= req_be;
            data_wdata_o <= req_wdata;
            pend_q.id    <= X_ID_WIDTH'(x_mem_req_i.id);
            pend_q.off   <= req_off;
            pend_q.size  <= x_mem_req_i.size;
            pend_q.we    <= x_mem_req_i.we;
          end
        end
        BUS_REQ: begin
          if (data_gnt_i) begin
            state_q    <= IDLE;
            data_req_o <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ptr_t'(1);
      if (pop)  rptr_q <= rptr_q + ptr_t'(1);
      if (push && !pop)      count_q <= count_q + cnt_t'(1);
      else if (pop && !push) count_q <= count_q - cnt_t'(1);
    end
  end

  // NOTE: the entry storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= pend_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_mem_result_valid_o <= 1'b0;
      x_mem_result_o       <= '0;
    end else begin
      x_mem_result_valid_o <= pop;
      if (pop) begin
        x_mem_result_o.id    <= X_ID_W'(head.id);
        x_mem_result_o.rdata <= load_rdata;
        x_mem_result_o.err   <= data_err_i;
        x_mem_result_o.dbg   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_x_mem_responder.sv
// Self-checking bench for x_mem_responder: directed vector table, multi-cycle sequences,
// and randomized traffic against a transaction-level queue model.
`timescale 1ns/1ps
module tb_x_mem_responder;
  import x_mem_responder_pkg::*;

  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          x_mem_valid;
  logic          x_mem_ready;
  x_mem_req_t    x_mem_req;
  x_mem_resp_t   x_mem_resp;
  logic          result_valid;
  x_mem_result_t result;
  logic          data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [31:0]   data_addr, data_wdata, data_rdata;
  logic [3:0]    data_be;

  always #5 clk = ~clk;

  x_mem_responder #(.X_ID_WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .x_mem_valid_i       (x_mem_valid),
    .x_mem_ready_o       (x_mem_ready),
    .x_mem_req_i         (x_mem_req),
    .x_mem_resp_o        (x_mem_resp),
    .x_mem_result_valid_o(result_valid),
    .x_mem_result_o      (result),
    .data_req_o          (data_req),
    .data_gnt_i          (data_gnt),
    .data_addr_o         (data_addr),
    .data_we_o           (data_we),
    .data_be_o           (data_be),
    .data_wdata_o        (data_wdata),
    .data_rvalid_i       (data_rvalid),
    .data_rdata_i        (data_rdata),
    .data_err_i          (data_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x_mem_valid = 1'b0;
    x_mem_req   = '0;
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_rdata  = '0;
    data_err    = 1'b0;
  endtask

  function automatic x_mem_req_t rand_req();
    x_mem_req_t r;
    r.id    = 4'($urandom);
    r.addr  = $urandom;
    r.mode  = 2'($urandom);
    r.size  = mem_size_e'($urandom_range(0, 3));
    r.we    = 1'($urandom);
    r.wdata = $urandom;
    r.last  = 1'($urandom);
    r.spec  = 1'($urandom);
    return r;
  endfunction

  // ---------------- reference rules ----------------
  function automatic bit ref_fault(input x_mem_req_t r);
`ifdef FPU_SS_MEM_MISALIGN_EXC_EN
    return (r.size == SIZE_DOUBLE) ||
           (r.size == SIZE_HALF && r.addr[0]) ||
           (r.size == SIZE_WORD && r.addr[1:0] != 2'b00);
`else
    return (r.size == SIZE_DOUBLE);
`endif
  endfunction

  function automatic logic [5:0] ref_code(input x_mem_req_t r);
    if (r.size == SIZE_DOUBLE) return r.we ? 6'd7 : 6'd5;
    return r.we ? 6'd6 : 6'd4;
  endfunction

  function automatic logic [3:0] ref_be(input x_mem_req_t r);
    int nbytes;
    int lanes;
    if (r.size == SIZE_WORD) return 4'hF;
    nbytes = (r.size == SIZE_BYTE) ? 1 : 2;
    lanes  = ((1 << nbytes) - 1) << int'(r.addr[1:0]);
    return lanes[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input x_mem_req_t r);
    return r.wdata << (8 * int'(r.addr[1:0]));
  endfunction

  function automatic logic [31:0] ref_rdata(input x_mem_req_t r, input logic [31:0] rd);
    logic [31:0] v;
    if (r.we) return 32'h0;
    v = rd >> (8 * int'(r.addr[1:0]));
    if (r.size == SIZE_BYTE) return v & 32'h0000_00FF;
    if (r.size == SIZE_HALF) return v & 32'h0000_FFFF;
    return v;
  endfunction

  // ---------------- transaction-level model ----------------
  x_mem_req_t  mq[$];
  bit          m_busy;
  x_mem_req_t  m_pend;
  bit          m_res_pend;
  logic [3:0]  m_res_id;
  logic [31:0] m_res_rdata;
  logic        m_res_err;

  task automatic model_reset();
    mq.delete();
    m_busy     = 1'b0;
    m_pend     = '0;
    m_res_pend = 1'b0;
  endtask

  // Compares one cycle of DUT outputs with the model, then advances the model across the edge.
  task automatic model_cycle();
    logic        exp_ready;
    bit          flt;
    x_mem_resp_t exp_resp;
    x_mem_req_t  e;
    @(negedge clk);
    exp_ready = x_mem_valid && !m_busy && (mq.size() < DEPTH);
    flt       = ref_fault(x_mem_req);
    exp_resp  = '0;
    if (exp_ready && flt) begin
      exp_resp.exc     = 1'b1;
      exp_resp.exccode = ref_code(x_mem_req);
    end
    check("rnd_ready", x_mem_ready, exp_ready);
    check("rnd_resp", x_mem_resp, exp_resp);
    check("rnd_data_req", data_req, m_busy);
    if (m_busy) begin
      check("rnd_addr", data_addr, {m_pend.addr[31:2], 2'b00});
      check("rnd_be", data_be, ref_be(m_pend));
      check("rnd_wdata", data_wdata, ref_wdata(m_pend));
      check("rnd_we", data_we, m_pend.we);
    end
    check("rnd_res_valid", result_valid, m_res_pend);
    if (m_res_pend) begin
      check("rnd_res_id", result.id, m_res_id);
      check("rnd_res_rdata", result.rdata, m_res_rdata);
      check("rnd_res_err", result.err, m_res_err);
      check("rnd_res_dbg", result.dbg, 1'b0);
    end
    m_res_pend = 1'b0;
    if (data_rvalid && mq.size() != 0) begin
      e           = mq.pop_front();
      m_res_pend  = 1'b1;
      m_res_id    = e.id;
      m_res_rdata = ref_rdata(e, data_rdata);
      m_res_err   = data_err;
    end
    if (m_busy) begin
      if (data_gnt) begin
        mq.push_back(m_pend);
        m_busy = 1'b0;
      end
    end else if (exp_ready && !flt) begin
      m_busy = 1'b1;
      m_pend = x_mem_req;
    end
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    mem_size_e   size;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  id;
    int          gnt_delay;
    logic [31:0] rdata;
    logic        err;
    logic        exp_exc;
    logic [5:0]  exp_code;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic fill_vecs();
    vecs[0] = '{SIZE_WORD, 1'b0, 32'h1000, 32'h0, 4'd3, 1, 32'hDEADBEEF, 1'b0,
                1'b0, 6'd0, 32'h1000, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[1] = '{SIZE_BYTE, 1'b1, 32'h1003, 32'h000000A5, 4'd5, 0, 32'h12345678, 1'b0,
                1'b0, 6'd0, 32'h1000, 4'b1000, 32'hA5000000, 32'h0};
    vecs[2] = '{SIZE_HALF, 1'b0, 32'h2002, 32'h0, 4'd7, 0, 32'hBEEF1234, 1'b0,
                1'b0, 6'd0, 32'h2000, 4'b1100, 32'h0, 32'h0000BEEF};
    vecs[3] = '{SIZE_HALF, 1'b0, 32'h2002, 32'h0, 4'd8, 2, 32'hBEEF1234, 1'b1,
                1'b0, 6'd0, 32'h2000, 4'b1100, 32'h0, 32'h0000BEEF};
    vecs[4] = '{SIZE_BYTE, 1'b0, 32'h3001, 32'h0, 4'd9, 0, 32'h11223344, 1'b0,
                1'b0, 6'd0, 32'h3000, 4'b0010, 32'h0, 32'h00000033};
    vecs[5] = '{SIZE_HALF, 1'b1, 32'h40, 32'hCAFEF00D, 4'd10, 5, 32'hFFFFFFFF, 1'b0,
                1'b0, 6'd0, 32'h40, 4'b0011, 32'hCAFEF00D, 32'h0};
    vecs[6] = '{SIZE_DOUBLE, 1'b0, 32'h5000, 32'h0, 4'd11, 0, 32'h0, 1'b0,
                1'b1, 6'd5, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[7] = '{SIZE_DOUBLE, 1'b1, 32'h5004, 32'h1, 4'd12, 0, 32'h0, 1'b0,
                1'b1, 6'd7, 32'h0, 4'h0, 32'h0, 32'h0};
`ifdef FPU_SS_MEM_MISALIGN_EXC_EN
    vecs[8] = '{SIZE_WORD, 1'b0, 32'h1001, 32'h0, 4'd13, 0, 32'hDEADBEEF, 1'b0,
                1'b1, 6'd4, 32'h0, 4'h0, 32'h0, 32'h0};
    vecs[9] = '{SIZE_HALF, 1'b1, 32'h1001, 32'h0000ABCD, 4'd14, 0, 32'h0, 1'b0,
                1'b1, 6'd6, 32'h0, 4'h0, 32'h0, 32'h0};
`else
    vecs[8] = '{SIZE_WORD, 1'b0, 32'h1001, 32'h0, 4'd13, 0, 32'hDEADBEEF, 1'b0,
                1'b0, 6'd0, 32'h1000, 4'hF, 32'h0, 32'h00DEADBE};
    vecs[9] = '{SIZE_HALF, 1'b1, 32'h1001, 32'h0000ABCD, 4'd14, 0, 32'h0, 1'b0,
                1'b0, 6'd0, 32'h1000, 4'b0110, 32'h00ABCD00, 32'h0};
`endif
  endtask

  task automatic check_bus(input string tag, input vec_t v);
    check({tag, "_req"}, data_req, 1'b1);
    check({tag, "_addr"}, data_addr, v.exp_addr);
    check({tag, "_be"}, data_be, v.exp_be);
    check({tag, "_wdata"}, data_wdata, v.exp_wdata);
    check({tag, "_we"}, data_we, v.we);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    x_mem_valid     = 1'b1;
    x_mem_req       = rand_req();
    x_mem_req.id    = v.id;
    x_mem_req.addr  = v.addr;
    x_mem_req.size  = v.size;
    x_mem_req.we    = v.we;
    x_mem_req.wdata = v.wdata;
    @(negedge clk);
    check({tag, "_ready"}, x_mem_ready, 1'b1);
    check({tag, "_exc"}, x_mem_resp.exc, v.exp_exc);
    check({tag, "_exccode"}, x_mem_resp.exccode, v.exp_code);
    check({tag, "_rdbg"}, x_mem_resp.dbg, 1'b0);
    tick();
    x_mem_valid = 1'b0;
    if (v.exp_exc) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check({tag, "_nobus"}, data_req, 1'b0);
        check({tag, "_nores"}, result_valid, 1'b0);
        tick();
      end
    end else begin
      for (int k = 0; k < v.gnt_delay; k++) begin
        x_mem_valid  = 1'b1;
        x_mem_req    = rand_req();
        @(negedge clk);
        check_bus({tag, "_hold"}, v);
        check({tag, "_hold_ready"}, x_mem_ready, 1'b0);
        tick();
      end
      x_mem_valid = 1'b0;
      data_gnt    = 1'b1;
      @(negedge clk);
      check_bus({tag, "_gnt"}, v);
      tick();
      data_gnt    = 1'b0;
      data_rvalid = 1'b1;
      data_rdata  = v.rdata;
      data_err    = v.err;
      @(negedge clk);
      check({tag, "_req_low"}, data_req, 1'b0);
      check({tag, "_early_res"}, result_valid, 1'b0);
      tick();
      data_rvalid = 1'b0;
      data_rdata  = '0;
      data_err    = 1'b0;
      @(negedge clk);
      check({tag, "_res_valid"}, result_valid, 1'b1);
      check({tag, "_res_id"}, result.id, v.id);
      check({tag, "_res_rdata"}, result.rdata, v.exp_rdata);
      check({tag, "_res_err"}, result.err, v.err);
      check({tag, "_res_dbg"}, result.dbg, 1'b0);
      tick();
      @(negedge clk);
      check({tag, "_res_once"}, result_valid, 1'b0);
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, x_mem_ready, 1'b0);
    check({tag, "_resp"}, x_mem_resp, '0);
    check({tag, "_res_valid"}, result_valid, 1'b0);
    check({tag, "_result"}, result, '0);
    check({tag, "_data_req"}, data_req, 1'b0);
    check({tag, "_addr"}, data_addr, '0);
    check({tag, "_we"}, data_we, 1'b0);
    check({tag, "_be"}, data_be, '0);
    check({tag, "_wdata"}, data_wdata, '0);
  endtask

  task automatic word_load(input logic [3:0] id, input logic [31:0] addr);
    x_mem_valid    = 1'b1;
    x_mem_req      = '0;
    x_mem_req.id   = id;
    x_mem_req.addr = addr;
    x_mem_req.size = SIZE_WORD;
  endtask

  // Three back-to-back loads with DEPTH 2 and no responses: the third waits for the first rvalid.
  task automatic seq_backpressure();
    data_gnt = 1'b1;
    word_load(4'd1, 32'h100);
    @(negedge clk); check("bp_a_ready", x_mem_ready, 1'b1); tick();
    word_load(4'd2, 32'h104);
    @(negedge clk); check("bp_busreq_ready", x_mem_ready, 1'b0); tick();
    @(negedge clk); check("bp_b_ready", x_mem_ready, 1'b1); tick();
    word_load(4'd3, 32'h108);
    @(negedge clk); check("bp_busreq2_ready", x_mem_ready, 1'b0); tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_full_ready", x_mem_ready, 1'b0);
      check("bp_full_req", data_req, 1'b0);
      tick();
    end
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_000A;
    @(negedge clk); check("bp_pop_cycle_ready", x_mem_ready, 1'b0); tick();
    data_rvalid = 1'b0;
    @(negedge clk);
    check("bp_res_a_valid", result_valid, 1'b1);
    check("bp_res_a_id", result.id, 4'd1);
    check("bp_res_a_rdata", result.rdata, 32'h0000_000A);
    check("bp_c_ready", x_mem_ready, 1'b1);
    tick();
    x_mem_valid = 1'b0;
    @(negedge clk);
    check("bp_c_req", data_req, 1'b1);
    check("bp_c_addr", data_addr, 32'h108);
    tick();
    data_gnt    = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h0000_000B;
    tick();
    data_rdata  = 32'h0000_000C;
    @(negedge clk);
    check("bp_res_b_id", result.id, 4'd2);
    check("bp_res_b_rdata", result.rdata, 32'h0000_000B);
    tick();
    data_rvalid = 1'b0;
    @(negedge clk);
    check("bp_res_c_valid", result_valid, 1'b1);
    check("bp_res_c_id", result.id, 4'd3);
    check("bp_res_c_rdata", result.rdata, 32'h0000_000C);
    tick();
    @(negedge clk); check("bp_res_end", result_valid, 1'b0); tick();
  endtask

  // Reset with two transactions outstanding; later responses must not produce results.
  task automatic seq_reset();
    data_gnt = 1'b1;
    word_load(4'd4, 32'h200);
    @(negedge clk); check("rs_a_ready", x_mem_ready, 1'b1); tick();
    x_mem_valid = 1'b0;
    tick();
    word_load(4'd5, 32'h204);
    @(negedge clk); check("rs_b_ready", x_mem_ready, 1'b1); tick();
    x_mem_valid = 1'b0;
    tick();
    data_gnt    = 1'b0;
    x_mem_valid = 1'b1;
    x_mem_req   = rand_req();
    rst_n       = 1'b0;
    #1;
    check_all_zero("rs_async");
    @(negedge clk);
    check_all_zero("rs_held");
    tick();
    rst_n       = 1'b1;
    x_mem_valid = 1'b0;
    data_rvalid = 1'b1;
    data_rdata  = 32'h5A5A_5A5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rs_no_result", result_valid, 1'b0);
      check("rs_no_req", data_req, 1'b0);
      tick();
    end
    data_rvalid = 1'b0;
    @(negedge clk);
    check_all_zero("rs_after");
    tick();
    run_vec(0, vecs[0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit drained;
    idle_inputs();
    #2;
    rst_n       = 1'b0;
    x_mem_valid = 1'b1;
    x_mem_req   = rand_req();
    @(negedge clk);
    check_all_zero("rst_init");
    tick();
    tick();
    rst_n       = 1'b1;
    x_mem_valid = 1'b0;
    tick();

    fill_vecs();
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);
    seq_backpressure();
    seq_reset();

    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      x_mem_valid = ($urandom_range(0, 99) < 60);
      x_mem_req   = rand_req();
      data_gnt    = 1'($urandom);
      data_rvalid = ($urandom_range(0, 99) < 35);
      data_rdata  = $urandom;
      data_err    = ($urandom_range(0, 9) == 0);
      model_cycle();
    end
    x_mem_valid = 1'b0;
    drained     = 1'b0;
    for (int c = 0; c < 50 && !drained; c++) begin
      data_gnt    = 1'b1;
      data_rvalid = 1'b1;
      data_rdata  = $urandom;
      data_err    = 1'b0;
      model_cycle();
      drained = (mq.size() == 0) && !m_busy && !m_res_pend;
    end
    check("drain_done", drained, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/x_mem_responder.md
X_MEM_RESPONDER -- requirements
Module: x_mem_responder

Interface
REQ-001 Parameter X_ID_WIDTH, default 4, width of the transaction id.
REQ-002 Parameter DEPTH, default 2, maximum number of outstanding bus transactions (power of two, 2..8).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 x_mem_valid_i  input  1  coprocessor memory request valid.
REQ-006 x_mem_ready_o  output  1  request accepted; x_mem_resp_o is valid in the same cycle.
REQ-007 x_mem_req_i  input  x_mem_req_t  id, addr, mode, size, we, wdata, last, spec.
REQ-008 x_mem_resp_o  output  x_mem_resp_t  exc, exccode, dbg.
REQ-009 x_mem_result_valid_o  output  1  one-cycle result strobe; there is no ready.
REQ-010 x_mem_result_o  output  x_mem_result_t  id, rdata, err, dbg.
REQ-011 data_req_o  output  1  data-bus request.
REQ-012 data_gnt_i  input  1  data-bus grant.
REQ-013 data_addr_o  output  32  word-aligned bus address.
REQ-014 data_we_o  output  1  bus write enable.
REQ-015 data_be_o  output  4  byte enables.
REQ-016 data_wdata_o  output  32  lane-aligned write data.
REQ-017 data_rvalid_i  input  1  bus response valid.
REQ-018 data_rdata_i  input  32  bus read data.
REQ-019 data_err_i  input  1  bus error, qualified by data_rvalid_i.

Function
REQ-020 The FSM SHALL have two states: IDLE and BUS_REQ.
REQ-021 In IDLE, x_mem_ready_o SHALL equal x_mem_valid_i AND (outstanding FIFO not full); a handshake captures the request into the bus registers and moves the FSM to BUS_REQ.
REQ-022 In BUS_REQ, data_req_o SHALL be 1 and the bus outputs SHALL be held stable until data_gnt_i = 1.
REQ-023 On a grant, the FSM SHALL push {id, addr[1:0], size, we} into the FIFO and return to IDLE; x_mem_ready_o SHALL be 0 throughout BUS_REQ.
REQ-024 Address, enables and data SHALL be formed as follows:
- data_addr_o = {addr[31:2], 2'b00}.
- data_be_o: Byte = 4'b0001 << addr[1:0]; HalfWord = 4'b0011 << addr[1:0]; Word = 4'b1111.
- data_wdata_o = wdata << (8*addr[1:0]).
REQ-025 size DoubleWord SHALL be treated as an access fault: exc = 1, exccode = 5 (load) or 7 (store), no bus transaction, no result.
REQ-026 x_mem_resp_o.dbg SHALL be 0; fields mode, last and spec SHALL not affect behaviour.
REQ-027 On data_rvalid_i with a non-empty FIFO, the head entry SHALL be popped.
REQ-028 In the cycle after that pop, x_mem_result_valid_o SHALL be 1 for exactly one cycle, carrying:
- id = entry id.
- err = data_err_i.
- dbg = 0.
- rdata for loads = data_rdata_i >> (8*addr[1:0]), zero-extended above the access size.
- rdata for stores = 0.
REQ-029 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-030 data_rvalid_i with an empty FIFO SHALL be ignored and SHALL not produce a result.
REQ-031 Results SHALL be returned in bus-response order, which equals the order of acceptance.

Reset
REQ-032 On rst_ni = 0, the FSM SHALL enter IDLE, the FIFO SHALL be emptied, and every output SHALL be driven to 0 (x_mem_resp_o = '0, x_mem_result_o = '0).
REQ-033 A reset during BUS_REQ or with transactions outstanding SHALL discard them, and no result SHALL be issued for them after release.

Configuration
REQ-034 With macro FPU_SS_MEM_MISALIGN_EXC_EN defined, a misaligned access SHALL complete its handshake in IDLE with exc = 1 and SHALL produce no bus transaction and no result:
- HalfWord with addr[0] = 1, or Word with addr[1:0] != 0.
- exccode = 4 for a load, 6 for a store.
REQ-035 Without FPU_SS_MEM_MISALIGN_EXC_EN, no alignment check SHALL be made: the access SHALL proceed with the shifted enables truncated to 4 bits and exc = 0.

Verification
REQ-036 Word load addr 0x1000, id 3; grant in cycle 2; rvalid with rdata 0xDEADBEEF -> data_be_o = 4'hF; one cycle later result id 3, rdata 0xDEADBEEF, err 0.
REQ-037 Byte store addr 0x1003, wdata 0x000000A5 -> data_addr_o 0x1000, data_be_o 4'b1000, data_wdata_o 0xA5000000; result rdata 0.
REQ-038 Grant withheld 5 cycles -> data_req_o and the bus outputs stay stable, x_mem_ready_o stays 0; three back-to-back requests with DEPTH 2 and no rvalid -> the third is not accepted until the first rvalid.
REQ-039 HalfWord load addr 0x2002 with rdata 0xBEEF1234 -> rdata 0x0000BEEF; with data_err_i = 1 -> err 1.
REQ-040 With the macro defined, Word load addr 0x1001 -> same-cycle ready with exc 1, exccode 4, no data_req_o, no result; without the macro -> bus request issued.
REQ-041 Reset asserted with 2 transactions outstanding, then rvalid after release -> no result, all outputs 0, FIFO empty.
